// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/forwarding logic: FSM state
// encodings, forwarding-source codes and the default special registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_LU       = 2'b01,
    ST_MEM_WAIT = 2'b10,
    ST_ERR      = 2'b11
  } fsm_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam int unsigned ZERO_REG_DEF  = 0;
  localparam int unsigned NOFWD_REG_DEF = 30;
  localparam int unsigned LINK_REG_DEF  = 31;

endpackage

// File: rtl/fwd_src_sel.sv
// Forwarding-source selection for one ID source operand. The youngest
// in-flight producer wins (EX > MEM > WB); the CALL link path in WB is the
// lowest-priority source before the register file.
module fwd_src_sel
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned ZERO_REG  = ZERO_REG_DEF,
  parameter int unsigned NOFWD_REG = NOFWD_REG_DEF,
  parameter int unsigned LINK_REG  = LINK_REG_DEF
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic              valid_i,
  input  logic [REG_AW-1:0] rw_ex_i,
  input  logic              regwrite_ex_i,
  input  logic [REG_AW-1:0] rw_mem_i,
  input  logic              regwrite_mem_i,
  input  logic [REG_AW-1:0] rw_wb_i,
  input  logic              regwrite_wb_i,
  input  logic              link_wb_i,
  output logic [1:0]        sel_o
);

  localparam logic [REG_AW-1:0] ZERO_A  = REG_AW'(ZERO_REG);
  localparam logic [REG_AW-1:0] NOFWD_A = REG_AW'(NOFWD_REG);
  localparam logic [REG_AW-1:0] LINK_A  = REG_AW'(LINK_REG);

  logic src_elig;
  logic ex_hit;
  logic mem_hit;
  logic wb_hit;
  logic link_hit;

  // A destination equal to an eligible source is itself eligible, so only
  // the source side needs the explicit eligibility test.
  assign src_elig = valid_i && (src_i != ZERO_A) && (src_i != NOFWD_A);
  assign ex_hit   = src_elig && regwrite_ex_i  && (rw_ex_i  == src_i);
  assign mem_hit  = src_elig && regwrite_mem_i && (rw_mem_i == src_i);
  assign wb_hit   = src_elig && regwrite_wb_i  && (rw_wb_i  == src_i);
  assign link_hit = valid_i && link_wb_i && (src_i == LINK_A);

  // Priority encode the forwarding source, youngest producer first.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sel_o = FWD_RF;
    if (ex_hit)        sel_o = FWD_EX;
    else if (mem_hit)  sel_o = FWD_MEM;
    else if (wb_hit)   sel_o = FWD_WB;
    else if (link_hit) sel_o = FWD_WB;
  end

endmodule

// File: rtl/hazard_fwd_scoreboard.sv
// ID-stage forwarding and stall controller. Selects a forwarding source per
// operand, stalls on load-use and on loads still waiting in MEM, tracks the
// wait in an FSM with a timeout watchdog, and counts stalled cycles.
module hazard_fwd_scoreboard
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned NUM_SRC   = 3,
  parameter int unsigned ZERO_REG  = ZERO_REG_DEF,
  parameter int unsigned NOFWD_REG = NOFWD_REG_DEF,
  parameter int unsigned LINK_REG  = LINK_REG_DEF,
  parameter int unsigned MAX_WAIT  = 15,
  parameter int unsigned WAIT_W    = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*REG_AW-1:0] src_addr,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [REG_AW-1:0]         rw_ex,
  input  logic                      regwrite_ex,
  input  logic                      mem_rd_ex,
  input  logic [REG_AW-1:0]         rw_mem,
  input  logic                      regwrite_mem,
  input  logic                      mem_rd_mem,
  input  logic                      mem_ack,
  input  logic [REG_AW-1:0]         rw_wb,
  input  logic                      regwrite_wb,
  input  logic                      link_wb,
  input  logic                      flush,
  input  logic                      cnt_clr,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      stall,
  output logic [1:0]                state,
  output logic                      timeout_err,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  logic [1:0]        sel_raw [NUM_SRC];
  logic              lu_haz;
  logic              mw_haz;
  fsm_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_sel #(
      .REG_AW   (REG_AW),
      .ZERO_REG (ZERO_REG),
      .NOFWD_REG(NOFWD_REG),
      .LINK_REG (LINK_REG)
    ) u_sel (
      .src_i         (src_addr[i*REG_AW +: REG_AW]),
      .valid_i       (src_valid[i]),
      .rw_ex_i       (rw_ex),
      .regwrite_ex_i (regwrite_ex),
      .rw_mem_i      (rw_mem),
      .regwrite_mem_i(regwrite_mem),
      .rw_wb_i       (rw_wb),
      .regwrite_wb_i (regwrite_wb),
      .link_wb_i     (link_wb),
      .sel_o         (sel_raw[i])
    );
  end

  // OR-reduce per-operand hazards and pack the selects; outputs are held at
  // RF while reset is asserted.
  always_comb begin
    lu_haz  = 1'b0;
    mw_haz  = 1'b0;
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if ((sel_raw[i] == FWD_EX) && mem_rd_ex) lu_haz = 1'b1;
      if ((sel_raw[i] == FWD_MEM) && mem_rd_mem && !mem_ack) mw_haz = 1'b1;
      fwd_sel[i*2 +: 2] = rst_n ? sel_raw[i] : FWD_RF;
    end
  end

  assign stall = rst_n && !flush && (lu_haz || mw_haz);

  // Next state, wait counter and sticky timeout flag.
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    err_d   = err_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_ERR) begin
      state_d = ST_ERR;
    end else if (lu_haz) begin
      state_d = ST_LU;
    end else if (mw_haz) begin
      if ((state_q == ST_MEM_WAIT) && (wait_q == WAIT_LAST)) begin
        state_d = ST_ERR;
        err_d   = 1'b1;
      end else begin
        state_d = ST_MEM_WAIT;
        wait_d  = wait_q + WAIT_W'(1);
      end
    end else begin
      state_d = ST_IDLE;
    end
  end

  // Saturating stall-cycle counter; clear beats a simultaneous increment.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)                         cnt_d = '0;
    else if (stall && (cnt_q != '1))     cnt_d = cnt_q + CNT_W'(1);
  end

  // State registers; all clear asynchronously, including mid-stall.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state       = state_q;
  assign timeout_err = err_q;
  assign stall_cnt   = cnt_q;

endmodule
